// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline memory stage.
// Holds the MEM-stage FSM encoding and the word-alignment helper.
package pipeline_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    function automatic logic word_aligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long the memory stage waits for dmem_ack.
// done fires in the counting cycle whose increment reaches TIMEOUT_CYCLES.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = en && (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, waits for ack with a
// timeout, and produces the MEM/WB register outputs.
import pipeline_pkg::*;

module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  mem_write_en,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     read_data_2,
    input  logic [REG_ADDR_W-1:0] rd_num,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] rd_num_out,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_err
);

    state_t state, state_nxt;

    logic mem_op, is_store, aligned, start_req;
    logic to_clr, to_en, to_done;

    // Instruction fields held for the duration of an outstanding request
    logic [REG_ADDR_W-1:0] rd_num_p1;
    logic                  reg_write_p1;
    logic                  store_p1;

    assign mem_op   = in_valid && (mem_to_reg || mem_write_en);
    assign is_store = mem_write_en;
    assign aligned  = word_aligned(alu_result);

    assign to_clr = (state == IDLE);
    assign to_en  = (state == WAIT_ACK) && !dmem_ack;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (to_clr),
        .en   (to_en),
        .done (to_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mem_op && aligned)   state_nxt = WAIT_ACK;
            WAIT_ACK: if (dmem_ack || to_done) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        start_req = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (mem_op && aligned) begin
                        stall     = 1'b1;
                        start_req = 1'b1;
                    end
                end
                WAIT_ACK: stall = !dmem_ack && !to_done;
            endcase
        end
    end

    // MEM/WB register and memory request register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            reg_write_out <= 1'b0;
            rd_num_out    <= '0;
            wb_data       <= '0;
            mem_err       <= 1'b0;
            rd_num_p1     <= '0;
            reg_write_p1  <= 1'b0;
            store_p1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid      <= in_valid && !start_req;
                    mem_err       <= mem_op && !aligned;
                    wb_data       <= alu_result;
                    rd_num_out    <= rd_num;
                    reg_write_out <= in_valid && !mem_op && reg_write && (rd_num != '0);
                    if (start_req) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= is_store;
                        dmem_addr    <= alu_result;
                        dmem_wdata   <= read_data_2;
                        rd_num_p1    <= rd_num;
                        reg_write_p1 <= reg_write;
                        store_p1     <= is_store;
                    end
                end
                WAIT_ACK: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        mem_err       <= 1'b0;
                        wb_data       <= store_p1 ? '0 : dmem_rdata;
                        rd_num_out    <= rd_num_p1;
                        reg_write_out <= !store_p1 && reg_write_p1 && (rd_num_p1 != '0);
                    end else if (to_done) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        mem_err       <= 1'b1;
                        wb_data       <= '0;
                        rd_num_out    <= rd_num_p1;
                        reg_write_out <= 1'b0;
                    end else begin
                        wb_valid      <= 1'b0;
                        mem_err       <= 1'b0;
                        reg_write_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of cycles spent in WAIT_ACK before a transaction is aborted.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  in  1  EX/MEM register holds a valid instruction.
REQ-005 mem_write_en, mem_to_reg, reg_write  in  1 each  control bits from the EX/MEM register.
REQ-006 alu_result  in  32  data address for memory ops, or the result for non-memory ops.
REQ-007 read_data_2  in  32  store data.
REQ-008 rd_num  in  5  destination register number.
REQ-009 stall  out  1  combinational; tells upstream to hold the EX/MEM inputs unchanged.
REQ-010 dmem_req, dmem_we  out  1 each  data-memory request and write strobe (registered).
REQ-011 dmem_addr, dmem_wdata  out  32 each  memory address and write data (registered).
REQ-012 dmem_rdata  in  32; dmem_ack  in  1  memory response, valid in the ack cycle only.
REQ-013 wb_valid, reg_write_out  out  1 each; rd_num_out  out  5; wb_data  out  32: MEM/WB register outputs.
REQ-014 mem_err  out  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-015 The FSM SHALL have two states, IDLE and WAIT_ACK.
REQ-016 A memory op is a cycle with in_valid=1 and (mem_to_reg=1 or mem_write_en=1).
REQ-017 If mem_write_en and mem_to_reg are both 1, the op SHALL be a store.
REQ-018 Non-memory op in IDLE: the next cycle SHALL give wb_valid=1 and wb_data=alu_result; stall=0; latency is 1 cycle.
REQ-019 Aligned memory op in IDLE (alu_result[1:0]=0): stall=1 that cycle, and the FSM SHALL enter WAIT_ACK.
REQ-020 Entering WAIT_ACK SHALL drive dmem_req=1 with dmem_addr=alu_result, dmem_we=store, and dmem_wdata=read_data_2.
REQ-021 These request outputs SHALL be held until ack or timeout.
REQ-022 In WAIT_ACK, stall=1 until the ack cycle; in the ack cycle stall=0 and dmem_req drops at the next edge.
REQ-023 Load completion: the cycle after ack SHALL give wb_valid=1, wb_data=dmem_rdata as captured at ack, and reg_write_out=reg_write.
REQ-024 Store completion: the cycle after ack SHALL give wb_valid=1 and reg_write_out=0.
REQ-025 The timeout counter SHALL clear on entering WAIT_ACK and increment each cycle without ack.
REQ-026 When the timeout count reaches TIMEOUT_CYCLES: return to IDLE, stall=0, and next cycle mem_err=1, wb_valid=1, reg_write_out=0.
REQ-027 If ack arrives in the same cycle the timeout would fire, ack SHALL win.
REQ-028 Misaligned memory op: no request is issued, stall=0, and next cycle mem_err=1, wb_valid=1, reg_write_out=0.
REQ-029 dmem_ack received in IDLE SHALL be ignored.
REQ-030 rd_num_out=0 SHALL force reg_write_out=0.
REQ-031 in_valid=0 in IDLE SHALL give wb_valid=0 and reg_write_out=0 next cycle.
REQ-032 rd_num_out SHALL always be the rd_num of the completing instruction.

Reset
REQ-033 rst_n=0 at an edge SHALL force state=IDLE, counter=0, and all registered outputs to 0, including wb_data and dmem_addr.
REQ-034 Reset during WAIT_ACK SHALL drop dmem_req at that edge and emit no wb_valid for the aborted op.
REQ-035 stall SHALL be 0 while rst_n=0.

Structure
REQ-036 Package pipeline_pkg SHALL hold the state enum (IDLE, WAIT_ACK), DATA_W=32, and REG_ADDR_W=5.
REQ-037 The timeout counter SHALL be the sub-module mem_timeout_ctr (ports: clr, en, done; parameter TIMEOUT_CYCLES); all other logic stays in mem_access_stage.

Verification
REQ-038 Non-memory op (alu_result=0x0000_1234, rd=5, reg_write=1) -> next cycle wb_valid=1, wb_data=0x1234, rd_num_out=5, stall=0 throughout.
REQ-039 Load, addr 0x100, ack after 3 cycles with rdata=0xDEAD_BEEF -> stall=1 for 3 cycles, then wb_data=0xDEADBEEF with reg_write_out=1.
REQ-040 Store, addr 0x204, wdata=0x55 -> dmem_we=1, dmem_wdata=0x55 held until ack; after ack wb_valid=1, reg_write_out=0.
REQ-041 Load with no ack (TIMEOUT_CYCLES=4) -> after 4 cycles in WAIT_ACK, stall falls, mem_err pulses 1 cycle, reg_write_out=0; also ack in the 4th cycle -> normal completion, mem_err=0.
REQ-042 Load at addr 0x102 -> dmem_req never asserted, mem_err=1 next cycle; also rst_n=0 mid-WAIT_ACK -> all outputs 0 at the next edge.
